// File: rtl/vga_timing_gen.sv
// vga_timing_gen: two-mode VGA raster timing generator.
// Mode switches take effect only at the frame wrap, so no partial frames are produced.
module vga_timing_gen #(
   parameter int          CNT_W     = 11,
   parameter logic [43:0] MODE0_H   = {11'd640, 11'd16, 11'd96, 11'd48},
   parameter logic [43:0] MODE0_V   = {11'd480, 11'd10, 11'd2, 11'd33},
   parameter logic [1:0]  MODE0_POL = 2'b00,
   parameter logic [43:0] MODE1_H   = {11'd800, 11'd40, 11'd128, 11'd88},
   parameter logic [43:0] MODE1_V   = {11'd600, 11'd1, 11'd4, 11'd23},
   parameter logic [1:0]  MODE1_POL = 2'b11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             mode,
   output logic             hs,
   output logic             vs,
   output logic             de,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             line_start,
   output logic             frame_start,
   output logic             mode_active
);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] H0_ACT = CNT_W'(MODE0_H[43:33]);
   localparam logic [CNT_W-1:0] H0_SS  = H0_ACT + CNT_W'(MODE0_H[32:22]);
   localparam logic [CNT_W-1:0] H0_SE  = H0_SS + CNT_W'(MODE0_H[21:11]);
   localparam logic [CNT_W-1:0] H0_TOT = H0_SE + CNT_W'(MODE0_H[10:0]);
   localparam logic [CNT_W-1:0] V0_ACT = CNT_W'(MODE0_V[43:33]);
   localparam logic [CNT_W-1:0] V0_SS  = V0_ACT + CNT_W'(MODE0_V[32:22]);
   localparam logic [CNT_W-1:0] V0_SE  = V0_SS + CNT_W'(MODE0_V[21:11]);
   localparam logic [CNT_W-1:0] V0_TOT = V0_SE + CNT_W'(MODE0_V[10:0]);
   localparam logic [CNT_W-1:0] H1_ACT = CNT_W'(MODE1_H[43:33]);
   localparam logic [CNT_W-1:0] H1_SS  = H1_ACT + CNT_W'(MODE1_H[32:22]);
   localparam logic [CNT_W-1:0] H1_SE  = H1_SS + CNT_W'(MODE1_H[21:11]);
   localparam logic [CNT_W-1:0] H1_TOT = H1_SE + CNT_W'(MODE1_H[10:0]);
   localparam logic [CNT_W-1:0] V1_ACT = CNT_W'(MODE1_V[43:33]);
   localparam logic [CNT_W-1:0] V1_SS  = V1_ACT + CNT_W'(MODE1_V[32:22]);
   localparam logic [CNT_W-1:0] V1_SE  = V1_SS + CNT_W'(MODE1_V[21:11]);
   localparam logic [CNT_W-1:0] V1_TOT = V1_SE + CNT_W'(MODE1_V[10:0]);
   logic [CNT_W-1:0] htot, vtot, h_nxt, v_nxt, h_act, h_ss, h_se, v_act, v_ss, v_se;
   logic h_last, v_last, wrap, m_nxt, hs_pol, vs_pol, hs_in, vs_in;
   // Wrap detection uses the running mode; sync/de of the next position use the mode that will be active there.
   always_comb begin
      htot   = mode_active ? H1_TOT : H0_TOT;
      vtot   = mode_active ? V1_TOT : V0_TOT;
      h_last = hcount == htot - ONE;
      v_last = vcount == vtot - ONE;
      wrap   = h_last && v_last;
      m_nxt  = wrap ? mode : mode_active;
      h_nxt  = h_last ? '0 : hcount + ONE;
      v_nxt  = !h_last ? vcount : v_last ? '0 : vcount + ONE;
      h_act  = m_nxt ? H1_ACT : H0_ACT;
      h_ss   = m_nxt ? H1_SS : H0_SS;
      h_se   = m_nxt ? H1_SE : H0_SE;
      v_act  = m_nxt ? V1_ACT : V0_ACT;
      v_ss   = m_nxt ? V1_SS : V0_SS;
      v_se   = m_nxt ? V1_SE : V0_SE;
      hs_pol = m_nxt ? MODE1_POL[1] : MODE0_POL[1];
      vs_pol = m_nxt ? MODE1_POL[0] : MODE0_POL[0];
      hs_in  = h_nxt >= h_ss && h_nxt < h_se;
      vs_in  = v_nxt >= v_ss && v_nxt < v_se;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hcount      <= H0_TOT - ONE;
         vcount      <= V0_TOT - ONE;
         hs          <= ~MODE0_POL[1];
         vs          <= ~MODE0_POL[0];
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         mode_active <= 1'b0;
      end else begin
         line_start  <= en && h_last;
         frame_start <= en && wrap;
         if (en) begin
            hcount      <= h_nxt;
            vcount      <= v_nxt;
            mode_active <= m_nxt;
            hs          <= hs_in ? hs_pol : ~hs_pol;
            vs          <= vs_in ? vs_pol : ~vs_pol;
            de          <= h_nxt < h_act && v_nxt < v_act;
         end
      end
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks a default-timing and a shrunken-timing instance against a
// linear pixel-position reference model, plus hand-written vectors for corner cases.
module tb_vga_timing_gen;
   logic clk = 0, reset = 0, en = 0, mode = 0;
   logic d_hs, d_vs, d_de, d_ls, d_fs, d_ma, s_hs, s_vs, s_de, s_ls, s_fs, s_ma;
   logic [10:0] d_h, d_v, s_h, s_v;
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;

   vga_timing_gen u_def (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .hs(d_hs), .vs(d_vs), .de(d_de),
      .hcount(d_h), .vcount(d_v), .line_start(d_ls), .frame_start(d_fs), .mode_active(d_ma));

   vga_timing_gen #(
      .MODE0_H({11'd16, 11'd2, 11'd3, 11'd2}), .MODE0_V({11'd10, 11'd1, 11'd2, 11'd2}), .MODE0_POL(2'b00),
      .MODE1_H({11'd20, 11'd3, 11'd4, 11'd3}), .MODE1_V({11'd12, 11'd1, 11'd3, 11'd2}), .MODE1_POL(2'b11)
   ) u_sml (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .hs(s_hs), .vs(s_vs), .de(s_de),
      .hcount(s_h), .vcount(s_v), .line_start(s_ls), .frame_start(s_fs), .mode_active(s_ma));

   // timing tables indexed [instance][mode]
   int ha[2][2]  = '{'{640, 800}, '{16, 20}};
   int hf[2][2]  = '{'{16, 40},   '{2, 3}};
   int hsy[2][2] = '{'{96, 128},  '{3, 4}};
   int hb[2][2]  = '{'{48, 88},   '{2, 3}};
   int va[2][2]  = '{'{480, 600}, '{10, 12}};
   int vf[2][2]  = '{'{10, 1},    '{1, 1}};
   int vsy[2][2] = '{'{2, 4},     '{2, 3}};
   int vb[2][2]  = '{'{33, 23},   '{2, 2}};
   bit [1:0] pl[2] = '{2'b00, 2'b11};
   int p[2], mm[2];
   bit mls[2], mfs[2];

   typedef struct {
      logic rst, en, mode;
      logic [27:0] exp;
   } vec_t;
   vec_t tbl[8];

   function automatic int ht(int i, int m);
      return ha[i][m] + hf[i][m] + hsy[i][m] + hb[i][m];
   endfunction
   function automatic int vt(int i, int m);
      return va[i][m] + vf[i][m] + vsy[i][m] + vb[i][m];
   endfunction
   function automatic logic [27:0] pk(logic a, logic b, logic c, logic d, logic e, logic f, logic [10:0] h, logic [10:0] v);
      return {a, b, c, d, e, f, h, v};
   endfunction
   function automatic logic [27:0] got(int i);
      return i == 0 ? {d_hs, d_vs, d_de, d_ls, d_fs, d_ma, d_h, d_v} : {s_hs, s_vs, s_de, s_ls, s_fs, s_ma, s_h, s_v};
   endfunction
   function automatic logic [27:0] expv(int i);
      int m, h, v;
      bit hin, vin;
      m = mm[i];
      h = p[i] % ht(i, m);
      v = p[i] / ht(i, m);
      hin = h >= ha[i][m] + hf[i][m] && h < ha[i][m] + hf[i][m] + hsy[i][m];
      vin = v >= va[i][m] + vf[i][m] && v < va[i][m] + vf[i][m] + vsy[i][m];
      return pk(hin ? pl[m][1] : !pl[m][1], vin ? pl[m][0] : !pl[m][0],
                h < ha[i][m] && v < va[i][m], mls[i], mfs[i], m == 1, 11'(h), 11'(v));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mm[i] = 0;
         p[i] = ht(i, 0) * vt(i, 0) - 1;
         mls[i] = 0;
         mfs[i] = 0;
      end
   endtask
   task automatic model_adv(bit e, bit m);
      for (int i = 0; i < 2; i++) begin
         mls[i] = 0;
         mfs[i] = 0;
         if (e) begin
            p[i] = (p[i] + 1) % (ht(i, mm[i]) * vt(i, mm[i]));
            mls[i] = p[i] % ht(i, mm[i]) == 0;
            if (p[i] == 0) begin
               mfs[i] = 1;
               mm[i] = m;
            end
         end
      end
   endtask
   task automatic chk(string nm, logic [31:0] g, logic [31:0] e);
      n_chk++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (packed hs,vs,de,ls,fs,ma,h[11],v[11])", nm, g, e);
      end
   endtask
   task automatic step(bit r, bit e, bit m);
      reset = r;
      en = e;
      mode = m;
      @(posedge clk);
      #1;
      if (!r) model_reset();
      else model_adv(e, m);
      chk("model_def", 32'(got(0)), 32'(expv(0)));
      chk("model_sml", 32'(got(1)), 32'(expv(1)));
   endtask

   initial begin
      bit r, e, m, seen;
      tbl[0] = '{1'b0, 1'b1, 1'b0, pk(1, 1, 0, 0, 0, 0, 22, 14)};
      tbl[1] = '{1'b1, 1'b0, 1'b0, pk(1, 1, 0, 0, 0, 0, 22, 14)};
      tbl[2] = '{1'b1, 1'b1, 1'b0, pk(1, 1, 1, 1, 1, 0, 0, 0)};
      tbl[3] = '{1'b1, 1'b1, 1'b0, pk(1, 1, 1, 0, 0, 0, 1, 0)};
      tbl[4] = '{1'b1, 1'b0, 1'b1, pk(1, 1, 1, 0, 0, 0, 1, 0)};
      tbl[5] = '{1'b0, 1'b1, 1'b1, pk(1, 1, 0, 0, 0, 0, 22, 14)};
      tbl[6] = '{1'b1, 1'b1, 1'b1, pk(0, 0, 1, 1, 1, 1, 0, 0)};
      tbl[7] = '{1'b1, 1'b1, 1'b0, pk(0, 0, 1, 0, 0, 1, 1, 0)};
      model_reset();
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].rst, tbl[i].en, tbl[i].mode);
         chk($sformatf("vec%0d", i), 32'(got(1)), 32'(tbl[i].exp));
      end
      // mode 0 free run: several small frames, default lines
      step(0, 1, 0);
      for (int k = 0; k < 1500; k++) step(1, 1, 0);
      // asynchronous reset mid-line on the default instance
      step(0, 1, 0);
      for (int k = 0; k < 301; k++) step(1, 1, 0);
      chk("pre_async_h", 32'(d_h), 300);
      #2 reset = 0;
      #1;
      chk("async_def", 32'(got(0)), 32'(pk(1, 1, 0, 0, 0, 0, 799, 524)));
      chk("async_sml", 32'(got(1)), 32'(pk(1, 1, 0, 0, 0, 0, 22, 14)));
      model_reset();
      step(1, 1, 0);
      chk("post_rst_fs", 32'({d_fs, d_ls, d_h, d_v}), 32'({2'b11, 22'd0}));
      // en freeze just before small-instance hsync
      step(0, 1, 0);
      step(1, 1, 0);
      for (int k = 0; k < 17; k++) step(1, 1, 0);
      for (int k = 0; k < 50; k++) begin
         step(1, 0, 0);
         chk("freeze", 32'({s_hs, s_vs, s_de, s_h}), 32'({3'b110, 11'd17}));
      end
      step(1, 1, 0);
      chk("resume_hs", 32'({s_hs, s_h}), 32'({1'b0, 11'd18}));
      // mid-frame mode request only takes effect at the wrap
      step(0, 1, 0);
      for (int k = 0; k < 400 && s_v != 5; k++) step(1, 1, 0);
      chk("reach_v5", 32'(s_v), 5);
      seen = 0;
      for (int k = 0; k < 1000 && !seen; k++) begin
         step(1, 1, 1);
         seen = s_fs;
         if (!seen) chk("mode_hold", 32'(s_ma), 0);
      end
      if (!seen) chk("mode_timeout", 0, 1);
      else chk("mode_switch", 32'({s_ma, s_hs, s_vs, s_h, s_v}), 32'({3'b100, 22'd0}));
      // alternating enable
      step(0, 1, 0);
      for (int k = 0; k < 2000; k++) step(1, k % 2 == 0, 0);
      // mode 1 held from reset on the default instance
      step(0, 1, 1);
      for (int k = 0; k < 2200; k++) step(1, 1, 1);
      chk("def_mode1_ma", 32'(d_ma), 1);
      // randomized enable / mode / occasional reset
      m = 0;
      for (int k = 0; k < 20000; k++) begin
         r = $urandom_range(0, 4999) != 0;
         e = $urandom_range(0, 3) != 0;
         if ($urandom_range(0, 299) == 0) m = !m;
         step(r, e, m);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
